irq_ctrl: RTL and testbench

Interrupt arbiter and sequencer for the 8-bit CPU. It synchronises the external interrupt pin, edge-detects the timer 0 and timer 1 `done` flags, and latches each event in a per-source pending bit. It masks the pending bits with the CPU configuration enables and presents a single prioritised request (source plus vector) to the CPU core. It then runs the acknowledge / return handshake, including the timer `done_ack` pulse. Only one interrupt is in service at a time; there is no nesting.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/irq_edge_sync.sv | 42 ++++
 rtl/irq_ctrl.sv | 115 +++++++++++
 tb/tb_irq_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// cpu_pkg: shared encodings, default vectors and config bit positions
// for the CPU interrupt controller.
package cpu_pkg;

  typedef enum logic [1:0] {
    IRQ_NONE = 2'd0,
    EI       = 2'd1,
    T0       = 2'd2,
    T1       = 2'd3
  } irq_src_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [9:0] EI_VECTOR_DEF = 10'h010;
  localparam logic [9:0] T0_VECTOR_DEF = 10'h020;
  localparam logic [9:0] T1_VECTOR_DEF = 10'h030;

  localparam int GIE_BIT  = 3;
  localparam int EIE_BIT  = 2;
  localparam int T0IE_BIT = 1;
  localparam int T1IE_BIT = 0;

  // Eligible bits are ordered {T1, T0, EI}; lowest index wins.
  function automatic irq_src_t irq_pick(input logic [2:0] elig);
    if (elig[0])      return EI;
    else if (elig[1]) return T0;
    else if (elig[2]) return T1;
    else              return IRQ_NONE;
  endfunction

  function automatic logic [2:0] irq_mask(input irq_src_t s);
    case (s)
      EI:      return 3'b001;
      T0:      return 3'b010;
      T1:      return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_edge_sync.sv
`default_nettype none
// irq_edge_sync: optional N-stage synchroniser followed by a
// rising-edge detector producing a one-cycle pulse.
module irq_edge_sync #(
  parameter int STAGES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic level;
  logic hist;

  generate
    if (STAGES == 0) begin : g_nosync
      assign level = d;
    end else begin : g_sync
      logic [STAGES-1:0] sync;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync <= '0;
        end else begin
          sync[0] <= d;
          for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
        end
      end
      assign level = sync[STAGES-1];
    end
  endgenerate

  // History resets low, so a level already high at reset release counts as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 1'b0;
    else        hist <= level;
  end

  assign pulse = level & ~hist;

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// irq_ctrl: latches EI/T0/T1 events, presents one prioritised request
// to the CPU and runs the acknowledge/return handshake (no nesting).
module irq_ctrl
  import cpu_pkg::*;
#(
  parameter logic [9:0] EI_VECTOR   = EI_VECTOR_DEF,
  parameter logic [9:0] T0_VECTOR   = T0_VECTOR_DEF,
  parameter logic [9:0] T1_VECTOR   = T1_VECTOR_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ext_int,
  input  logic       t0_done,
  input  logic       t1_done,
  input  logic [3:0] cpu_cfg,
  input  logic       irq_ack,
  input  logic       irq_ret,
  output logic       irq_req,
  output logic [1:0] irq_src,
  output logic [9:0] irq_vector,
  output logic       in_service,
  output logic       done_ack_t0,
  output logic       done_ack_t1,
  output logic [2:0] pending
);

  localparam int SYNC_EFF = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic       ei_edge, t0_edge, t1_edge;
  logic       gie, src_live, take_ack;
  logic [2:0] en, edges, eligible, ack_clr;
  irq_src_t   src_q, pick;
  irq_state_t state;

  irq_edge_sync #(.STAGES(SYNC_EFF)) u_ei (.clk(clk), .rst_n(rst_n), .d(ext_int), .pulse(ei_edge));
  irq_edge_sync #(.STAGES(0))        u_t0 (.clk(clk), .rst_n(rst_n), .d(t0_done), .pulse(t0_edge));
  irq_edge_sync #(.STAGES(0))        u_t1 (.clk(clk), .rst_n(rst_n), .d(t1_done), .pulse(t1_edge));

  assign gie      = cpu_cfg[GIE_BIT];
  assign en       = {cpu_cfg[T1IE_BIT], cpu_cfg[T0IE_BIT], cpu_cfg[EIE_BIT]};
  assign edges    = {t1_edge, t0_edge, ei_edge};
  assign eligible = pending & en & {3{gie}};
  assign pick     = irq_pick(eligible);
  assign src_live = gie & (|(irq_mask(src_q) & en));
  assign take_ack = (state == REQUEST) && src_live && irq_ack;
  assign ack_clr  = take_ack ? irq_mask(src_q) : 3'b000;

  function automatic logic [9:0] vec_of(input irq_src_t s);
    case (s)
      EI:      return EI_VECTOR;
      T0:      return T0_VECTOR;
      T1:      return T1_VECTOR;
      default: return 10'h000;
    endcase
  endfunction

  // A new edge in the same cycle as the ack clear keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= 3'b000;
    else        pending <= (edges & en) | (pending & en & ~ack_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      src_q       <= IRQ_NONE;
      irq_req     <= 1'b0;
      irq_src     <= 2'd0;
      irq_vector  <= 10'h000;
      in_service  <= 1'b0;
      done_ack_t0 <= 1'b0;
      done_ack_t1 <= 1'b0;
    end else begin
      done_ack_t0 <= 1'b0;
      done_ack_t1 <= 1'b0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            state      <= REQUEST;
            src_q      <= pick;
            irq_req    <= 1'b1;
            irq_src    <= pick;
            irq_vector <= vec_of(pick);
          end
        end
        REQUEST: begin
          if (!src_live || irq_ack) begin
            irq_req    <= 1'b0;
            irq_src    <= 2'd0;
            irq_vector <= 10'h000;
            if (!src_live) begin
              state <= IDLE;
            end else begin
              state       <= SERVICE;
              in_service  <= 1'b1;
              done_ack_t0 <= (src_q == T0);
              done_ack_t1 <= (src_q == T1);
            end
          end
        end
        SERVICE: begin
          if (irq_ret) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// tb_irq_ctrl: table-driven scoreboard bench for irq_ctrl plus a
// hand-written asynchronous-reset-during-service sequence.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ext_int = 1'b0, t0_done = 1'b0, t1_done = 1'b0;
  logic [3:0] cpu_cfg = 4'b0000;
  logic       irq_ack = 1'b0, irq_ret = 1'b0;
  logic       irq_req, in_service, done_ack_t0, done_ack_t1;
  logic [1:0] irq_src;
  logic [9:0] irq_vector;
  logic [2:0] pending;

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ext_int(ext_int), .t0_done(t0_done), .t1_done(t1_done),
    .cpu_cfg(cpu_cfg), .irq_ack(irq_ack), .irq_ret(irq_ret), .irq_req(irq_req),
    .irq_src(irq_src), .irq_vector(irq_vector), .in_service(in_service),
    .done_ack_t0(done_ack_t0), .done_ack_t1(done_ack_t1), .pending(pending)
  );

  typedef struct packed {
    logic       req;
    logic [1:0] src;
    logic [9:0] vec;
    logic       svc;
    logic       da0;
    logic       da1;
    logic [2:0] pend;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       ext, t0, t1;
    logic [3:0] cfg;
    logic       ack, ret;
    outs_t      exp;
  } vec_t;

  vec_t  tbl[$];
  outs_t sb[$];
  outs_t act;
  int    n_checks = 0;
  int    n_fail = 0;

  assign act = {irq_req, irq_src, irq_vector, in_service, done_ack_t0, done_ack_t1, pending};

  function automatic outs_t o(int req, int src, int vec, int svc, int da0, int da1, int pend);
    outs_t r;
    r.req  = req[0];
    r.src  = src[1:0];
    r.vec  = vec[9:0];
    r.svc  = svc[0];
    r.da0  = da0[0];
    r.da1  = da1[0];
    r.pend = pend[2:0];
    return r;
  endfunction

  task automatic add(input int rst, input int ext, input int t0, input int t1, input int cfg,
                     input int ack, input int ret, input outs_t e);
    vec_t v;
    v.rst = rst[0]; v.ext = ext[0]; v.t0 = t0[0]; v.t1 = t1[0];
    v.cfg = cfg[3:0]; v.ack = ack[0]; v.ret = ret[0]; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic compare(input string name, input int idx);
    outs_t e;
    e = sb.pop_front();
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s[%0d]: got req=%b src=%0d vec=%h svc=%b da0=%b da1=%b pend=%b, expected req=%b src=%0d vec=%h svc=%b da0=%b da1=%b pend=%b",
               name, idx, act.req, act.src, act.vec, act.svc, act.da0, act.da1, act.pend,
               e.req, e.src, e.vec, e.svc, e.da0, e.da1, e.pend);
    end
  endtask

  task automatic zero_inputs();
    ext_int = 1'b0; t0_done = 1'b0; t1_done = 1'b0;
    cpu_cfg = 4'b0000; irq_ack = 1'b0; irq_ret = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    zero_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    if (v.rst) do_reset();
    @(negedge clk);
    ext_int = v.ext; t0_done = v.t0; t1_done = v.t1;
    cpu_cfg = v.cfg; irq_ack = v.ack; irq_ret = v.ret;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    compare("vec", idx);
  endtask

  localparam int C1100 = 12, C1111 = 15, C1001 = 9, C0100 = 4, C1000 = 8, C1010 = 10;

  initial begin
    outs_t zero;
    vec_t  hv;
    zero = o(0, 0, 0, 0, 0, 0, 0);

    // External interrupt round trip: request 4 cycles after the rise.
    add(1, 1,0,0, C1100, 0,0, zero);
    add(0, 0,0,0, C1100, 0,0, zero);
    add(0, 0,0,0, C1100, 0,0, o(0,0,0,0,0,0,3'b001));
    add(0, 0,0,0, C1100, 0,0, o(1,1,10'h010,0,0,0,3'b001));
    add(0, 0,0,0, C1100, 1,0, o(0,0,0,1,0,0,3'b000));
    add(0, 0,0,0, C1100, 0,0, o(0,0,0,1,0,0,3'b000));
    add(0, 0,0,0, C1100, 0,1, zero);
    add(0, 0,0,0, C1100, 0,0, zero);
    // Priority and freeze: T0 beats T1, later EI does not preempt.
    add(1, 0,1,1, C1111, 0,0, o(0,0,0,0,0,0,3'b110));
    add(0, 0,1,1, C1111, 0,0, o(1,2,10'h020,0,0,0,3'b110));
    add(0, 1,1,1, C1111, 0,0, o(1,2,10'h020,0,0,0,3'b110));
    add(0, 0,1,1, C1111, 0,0, o(1,2,10'h020,0,0,0,3'b110));
    add(0, 0,1,1, C1111, 0,0, o(1,2,10'h020,0,0,0,3'b111));
    add(0, 0,1,1, C1111, 1,0, o(0,0,0,1,1,0,3'b101));
    add(0, 0,1,1, C1111, 0,0, o(0,0,0,1,0,0,3'b101));
    add(0, 0,1,1, C1111, 0,1, o(0,0,0,0,0,0,3'b101));
    add(0, 0,1,1, C1111, 0,0, o(1,1,10'h010,0,0,0,3'b101));
    add(0, 0,1,1, C1111, 1,0, o(0,0,0,1,0,0,3'b100));
    add(0, 0,1,1, C1111, 0,1, o(0,0,0,0,0,0,3'b100));
    add(0, 0,1,1, C1111, 0,0, o(1,3,10'h030,0,0,0,3'b100));
    add(0, 0,1,1, C1111, 1,0, o(0,0,0,1,0,1,3'b000));
    add(0, 0,1,1, C1111, 0,1, zero);
    add(0, 0,1,1, C1111, 0,0, zero);
    // Timer 1 acknowledge pulse; held done level does not re-pend.
    add(1, 0,0,1, C1001, 0,0, o(0,0,0,0,0,0,3'b100));
    add(0, 0,0,1, C1001, 0,0, o(1,3,10'h030,0,0,0,3'b100));
    add(0, 0,0,1, C1001, 1,0, o(0,0,0,1,0,1,3'b000));
    add(0, 0,0,1, C1001, 0,0, o(0,0,0,1,0,0,3'b000));
    add(0, 0,0,1, C1001, 0,1, zero);
    add(0, 0,0,1, C1001, 0,0, zero);
    // Masking: pending without GIE, GIE raises request, EIE drop cancels.
    add(1, 1,0,0, C0100, 0,0, zero);
    add(0, 0,0,0, C0100, 0,0, zero);
    add(0, 0,0,0, C0100, 0,0, o(0,0,0,0,0,0,3'b001));
    add(0, 0,0,0, C0100, 0,0, o(0,0,0,0,0,0,3'b001));
    add(0, 0,0,0, C1100, 0,0, o(1,1,10'h010,0,0,0,3'b001));
    add(0, 0,0,0, C1000, 0,0, zero);
    add(0, 0,0,0, C1000, 0,0, zero);
    // Set wins over ack clear; second request one cycle after return.
    add(1, 0,1,0, C1010, 0,0, o(0,0,0,0,0,0,3'b010));
    add(0, 0,0,0, C1010, 0,0, o(1,2,10'h020,0,0,0,3'b010));
    add(0, 0,1,0, C1010, 1,0, o(0,0,0,1,1,0,3'b010));
    add(0, 0,1,0, C1010, 0,0, o(0,0,0,1,0,0,3'b010));
    add(0, 0,1,0, C1010, 0,1, o(0,0,0,0,0,0,3'b010));
    add(0, 0,1,0, C1010, 0,0, o(1,2,10'h020,0,0,0,3'b010));
    add(0, 0,1,0, C1010, 1,0, o(0,0,0,1,1,0,3'b000));
    add(0, 0,1,0, C1010, 0,1, zero);
    // Spurious ack/ret in IDLE do nothing; normal operation follows.
    add(1, 0,0,0, C1111, 1,0, zero);
    add(0, 0,0,0, C1111, 0,1, zero);
    add(0, 0,0,0, C1111, 1,1, zero);
    add(0, 0,1,0, C1111, 0,0, o(0,0,0,0,0,0,3'b010));
    add(0, 0,1,0, C1111, 0,0, o(1,2,10'h020,0,0,0,3'b010));

    // Reset state, sampled while reset is held.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(zero);
    compare("reset_state", 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Asynchronous reset mid-SERVICE with a done_ack pulse in flight.
    hv.rst = 1'b1; hv.ext = 1'b0; hv.t0 = 1'b0; hv.t1 = 1'b1; hv.cfg = 4'b1001;
    hv.ack = 1'b0; hv.ret = 1'b0; hv.exp = o(0,0,0,0,0,0,3'b100);
    apply(hv, 100);
    hv.rst = 1'b0; hv.exp = o(1,3,10'h030,0,0,0,3'b100);
    apply(hv, 101);
    hv.ack = 1'b1; hv.exp = o(0,0,0,1,0,1,3'b000);
    apply(hv, 102);
    #2;
    rst_n = 1'b0;
    zero_inputs();
    #1;
    sb.push_back(zero);
    compare("async_reset", 103);
    @(negedge clk);
    rst_n = 1'b1;
    hv.t1 = 1'b0; hv.ack = 1'b0; hv.cfg = 4'b1111; hv.exp = zero;
    apply(hv, 104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
